fifo_read_ctrl: RTL and testbench

- Drain-side controller for the team's 7-deep, 32-bit shift-register FIFO, which has no full/empty flags.
- Mirrors FIFO occupancy by observing the write strobe and drives the FIFO's read enable.
- Captures read data, which arrives one cycle after the read strobe, into a 2-entry output buffer and presents it as a valid/ready stream.
- Also exports full/empty to the upstream writer and supports a flush that discards all stored words.

---
 rtl/fifo_read_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fifo_read_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_read_ctrl                                             |
// | Description : Drain-side controller for a flagless shift-register FIFO.  |
// |               Mirrors FIFO occupancy from the write strobe, issues read  |
// |               strobes, catches the one-cycle-late read data in a         |
// |               2-entry output buffer and presents it as a valid/ready     |
// |               stream. Exports full/empty upstream and supports a flush   |
// |               that discards every stored word.                           |
// | Ports       : clk, rst (async, active-low)                               |
// |               fifo_enable_write (in, monitored) / fifo_enable_read (out) |
// |               fifo_value_to_read (in) : FIFO data, one cycle after read  |
// |               fifo_full / fifo_empty (out) : mirrored occupancy flags    |
// |               m_data / m_valid (out), m_ready (in) : output stream       |
// |               flush (in) / flush_done (out, one-cycle pulse)             |
// |               stat_delivered / stat_dropped (out, optional)              |
// | Options     : define FIFO_READ_CTRL_STATS_EN to add the saturating       |
// |               delivered/dropped statistics counters and their ports.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_read_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 7,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_enable_write,
    output logic              fifo_enable_read,
    input  logic [DATA_W-1:0] fifo_value_to_read,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              flush,
    output logic              flush_done
`ifdef FIFO_READ_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_delivered,
    output logic [7:0]        stat_dropped
`endif
);

    localparam logic [1:0]       c_ST_IDLE   = 2'd0;
    localparam logic [1:0]       c_ST_STREAM = 2'd1;
    localparam logic [1:0]       c_ST_FLUSH  = 2'd2;
    localparam logic [CNT_W-1:0] c_DEPTH     = CNT_W'(DEPTH);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic [1:0]        r_buf_occ;

    logic w_in_flush;
    logic w_pop;
    logic w_push;
    logic w_credit_ok;
    logic w_rd;
    logic w_wr_acc;
    logic w_flush_start;
    logic w_flush_exit;

    assign w_in_flush    = (r_state == c_ST_FLUSH);
    assign w_pop         = m_valid & m_ready;
    assign w_flush_start = flush & ~w_in_flush;
    assign w_flush_exit  = w_in_flush & (r_count == '0) & ~r_inflight;

    // A read issued now lands in the buffer next cycle; it is only safe if
    // buffered + in-flight words still leave a slot after this cycle's pop.
    assign w_credit_ok = ({1'b0, r_buf_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    // Reading an empty FIFO returns garbage, so count>0 gates every read.
    // During a flush the buffer is bypassed, so reads are not credit-limited.
    assign w_rd = (r_count != '0) & (w_in_flush | w_credit_ok);

    // The FIFO keeps a write that arrives while full if it is read in the
    // same cycle, so acceptance mirrors that.
    assign w_wr_acc    = fifo_enable_write & ((r_count < c_DEPTH) | w_rd);
    assign w_count_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd);

    // Returned data is dropped while flushing and in the cycle flush starts.
    assign w_push = r_inflight & ~w_in_flush & ~w_flush_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_inflight <= w_rd;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        fifo_enable_read = w_rd;
        fifo_full        = (r_count == c_DEPTH);
        fifo_empty       = (r_count == '0);
        m_valid          = (r_buf_occ != 2'd0) & ~w_in_flush;
        m_data           = r_buf0;
        flush_done       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (flush) begin
                    w_state_nxt = c_ST_FLUSH;
                end else if ((r_count != '0) || (r_buf_occ != 2'd0)) begin
                    w_state_nxt = c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                if (flush) begin
                    w_state_nxt = c_ST_FLUSH;
                end else if ((r_count == '0) && !r_inflight && (r_buf_occ == 2'd0)) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_FLUSH: begin
                if (w_flush_exit) begin
                    w_state_nxt = c_ST_IDLE;
                    flush_done  = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Two-entry output buffer; r_buf0 is always the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_buf_occ <= 2'd0;
        end else if (w_flush_start || w_in_flush) begin
            r_buf_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_buf_occ == 2'd0) begin
                        r_buf0 <= fifo_value_to_read;
                    end else begin
                        r_buf1 <= fifo_value_to_read;
                    end
                    r_buf_occ <= r_buf_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0    <= r_buf1;
                    r_buf_occ <= r_buf_occ - 2'd1;
                end
                2'b11: begin
                    if (r_buf_occ == 2'd1) begin
                        r_buf0 <= fifo_value_to_read;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_value_to_read;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_READ_CTRL_STATS_EN
    logic [15:0] r_stat_delivered;
    logic [7:0]  r_stat_dropped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_delivered <= '0;
            r_stat_dropped   <= '0;
        end else if (w_flush_exit) begin
            r_stat_delivered <= '0;
            r_stat_dropped   <= '0;
        end else begin
            if (w_pop && (r_stat_delivered != '1)) begin
                r_stat_delivered <= r_stat_delivered + 16'd1;
            end
            if (fifo_enable_write && (r_count == c_DEPTH) && !w_rd && (r_stat_dropped != '1)) begin
                r_stat_dropped <= r_stat_dropped + 8'd1;
            end
        end
    end

    assign stat_delivered = r_stat_delivered;
    assign stat_dropped   = r_stat_dropped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_read_ctrl                                          |
// | Description : Self-checking bench for fifo_read_ctrl. Holds a queue      |
// |               model of the 7-deep FIFO (which also feeds the DUT read    |
// |               data) and a queue of words owed to the downstream.         |
// |               Honours FIFO_READ_CTRL_STATS_EN for the statistics ports.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_read_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr, rdy, fl;
    logic [31:0] wdata;
    logic        fifo_enable_read, fifo_full, fifo_empty, m_valid, flush_done;
    logic [31:0] m_data;
    logic [31:0] pend_d;
    logic [15:0] stat_delivered;
    logic [7:0]  stat_dropped;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] fq[$];     // words held inside the FIFO
    logic [31:0] oq[$];     // words returned by the FIFO, owed downstream
    logic [31:0] got_q[$];  // words actually handed over by the DUT
    bit          pend_v;    // a FIFO read is returning data this cycle
    bit          flushing;
    int          m_del, m_drop, rd_cnt;

    // Per-cycle expected and observed values
    bit          exp_rd, exp_valid, exp_full, exp_empty, exp_done;
    logic [31:0] exp_data;
    logic        obs_rd, obs_valid, obs_full, obs_empty, obs_done;
    logic [31:0] obs_data;
    logic [15:0] obs_sdel;
    logic [7:0]  obs_sdrop;

    always #5 clk = ~clk;

    fifo_read_ctrl #(.DATA_W(32), .DEPTH(7), .CNT_W(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .fifo_enable_write  (wr),
        .fifo_enable_read   (fifo_enable_read),
        .fifo_value_to_read (pend_d),
        .fifo_full          (fifo_full),
        .fifo_empty         (fifo_empty),
        .m_data             (m_data),
        .m_valid            (m_valid),
        .m_ready            (rdy),
        .flush              (fl),
        .flush_done         (flush_done)
`ifdef FIFO_READ_CTRL_STATS_EN
        ,
        .stat_delivered     (stat_delivered),
        .stat_dropped       (stat_dropped)
`endif
    );

`ifndef FIFO_READ_CTRL_STATS_EN
    assign stat_delivered = 16'h0;
    assign stat_dropped   = 8'h0;
`endif

    task automatic reset_model();
        fq.delete(); oq.delete();
        pend_v = 0; flushing = 0; m_del = 0; m_drop = 0;
    endtask

    // One clock cycle: called at a falling edge, returns at the next one.
    task automatic tick(input bit w, input logic [31:0] d, input bit r, input bit f);
        bit pop, acc, fl_old;
        int sz;
        wr = w; wdata = d; rdy = r; fl = f;
        sz        = fq.size();
        fl_old    = flushing;
        exp_valid = oq.size() > 0;
        exp_data  = exp_valid ? oq[0] : 32'h0;
        pop       = exp_valid && r;
        exp_rd    = (sz > 0) && (flushing || (oq.size() + int'(pend_v) < 2 + int'(pop)));
        exp_full  = (sz == 7);
        exp_empty = (sz == 0);
        exp_done  = flushing && (sz == 0) && !pend_v;
        #1;
        obs_rd = fifo_enable_read; obs_valid = m_valid; obs_data = m_data;
        obs_full = fifo_full; obs_empty = fifo_empty; obs_done = flush_done;
        obs_sdel = stat_delivered; obs_sdrop = stat_dropped;
        @(posedge clk);
        #1;
        if (obs_valid && r) got_q.push_back(obs_data);
        if (obs_rd) rd_cnt++;
        if (exp_done) begin
            flushing = 0; m_del = 0; m_drop = 0;
        end else begin
            if (pop && m_del < 65535) m_del++;
            if (w && sz == 7 && !obs_rd && m_drop < 255) m_drop++;
        end
        if (pop) void'(oq.pop_front());
        if (f && !fl_old) begin
            flushing = 1;
            oq.delete();
        end
        if (pend_v && !flushing) oq.push_back(pend_d);
        // FIFO hardware behaviour, driven by the real read strobe
        acc = w && (sz < 7 || obs_rd);
        pend_v = obs_rd;
        if (obs_rd) pend_d = (fq.size() > 0) ? fq.pop_front() : 32'hDEAD_DEAD;
        if (acc) fq.push_back(d);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (fq.size() > 0 || oq.size() > 0 || pend_v || flushing); i++)
            tick(0, 32'h0, 1, 0);
        tick(0, 32'h0, 1, 0);
    endtask

    task automatic test_reset();
        n_vec++;
        if ({fifo_enable_read, m_valid, fifo_full, fifo_empty, flush_done, m_data, stat_delivered, stat_dropped}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 8'h0}) begin
            n_err++;
            $display("FAIL reset_power_on: rd/valid/full/empty/done=%b%b%b%b%b data=%h required 00010 data=0",
                     fifo_enable_read, m_valid, fifo_full, fifo_empty, flush_done, m_data);
        end
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) tick(1, 32'hC0 + i, 0, 0);
        #2;
        rst = 1'b0;
        reset_model();
        #1;
        n_vec++;
        if ({fifo_enable_read, m_valid, fifo_full, fifo_empty, flush_done, stat_delivered, stat_dropped}
            !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 8'h0}) begin
            n_err++;
            $display("FAIL reset_mid_stream: rd/valid/full/empty/done=%b%b%b%b%b required 00010",
                     fifo_enable_read, m_valid, fifo_full, fifo_empty, flush_done);
        end
        @(negedge clk);
        rst = 1'b1;
        tick(0, 32'h0, 1, 0);
        n_vec++;
        if (obs_empty !== 1'b1 || obs_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after_release: empty=%b valid=%b required empty=1 valid=0", obs_empty, obs_valid);
        end
    endtask

    task automatic test_latency();
        logic [31:0] seq [3] = '{32'hA1, 32'hA2, 32'hA3};
        drain();
        tick(1, 32'hA1, 1, 0);
        n_vec++;
        if (obs_rd !== 1'b0) begin n_err++; $display("FAIL lat_no_read_on_write: rd=%b required 0", obs_rd); end
        tick(1, 32'hA2, 1, 0);
        n_vec++;
        if (obs_rd !== 1'b1) begin n_err++; $display("FAIL lat_read_next: rd=%b required 1", obs_rd); end
        tick(1, 32'hA3, 1, 0);
        n_vec++;
        if (obs_valid !== 1'b0) begin n_err++; $display("FAIL lat_valid_early: valid=%b required 0", obs_valid); end
        for (int i = 0; i < 3; i++) begin
            tick(0, 32'h0, 1, 0);
            n_vec++;
            if (obs_valid !== 1'b1 || obs_data !== seq[i]) begin
                n_err++;
                $display("FAIL lat_data%0d: valid=%b data=%h required valid=1 data=%h", i, obs_valid, obs_data, seq[i]);
            end
        end
        tick(0, 32'h0, 1, 0);
        n_vec++;
        if (obs_valid !== 1'b0 || obs_empty !== 1'b1) begin
            n_err++;
            $display("FAIL lat_end: valid=%b empty=%b required valid=0 empty=1", obs_valid, obs_empty);
        end
    endtask

    task automatic test_empty_write();
        int k;
        drain();
        got_q.delete();
        tick(1, 32'h77, 1, 0);
        n_vec++;
        if (obs_rd !== 1'b0) begin n_err++; $display("FAIL empty_write_same_cycle: rd=%b required 0", obs_rd); end
        tick(0, 32'h0, 1, 0);
        n_vec++;
        if (obs_rd !== 1'b1) begin n_err++; $display("FAIL empty_write_next_cycle: rd=%b required 1", obs_rd); end
        for (k = 0; k < 10 && got_q.size() == 0; k++) tick(0, 32'h0, 1, 0);
        n_vec++;
        if (got_q.size() != 1 || got_q[0] !== 32'h77) begin
            n_err++;
            $display("FAIL empty_write_data: got %0d words first=%h required 1 word 00000077",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
        end
    endtask

    task automatic test_full_backpressure();
        drain();
        got_q.delete();
        rd_cnt = 0;
        for (int i = 1; i <= 9; i++) tick(1, i, 0, 0);
        tick(0, 32'h0, 0, 0);
        n_vec++;
        if (obs_full !== 1'b1 || rd_cnt != 2 || obs_valid !== 1'b1 || obs_data !== 32'h1) begin
            n_err++;
            $display("FAIL full_hold: full=%b reads=%0d valid=%b data=%h required full=1 reads=2 valid=1 data=1",
                     obs_full, rd_cnt, obs_valid, obs_data);
        end
        tick(1, 32'd10, 0, 0);
        tick(1, 32'd11, 0, 0);
        tick(0, 32'h0, 0, 0);
`ifdef FIFO_READ_CTRL_STATS_EN
        n_vec++;
        if (obs_sdrop !== 8'd2) begin
            n_err++;
            $display("FAIL stat_dropped: got %0d required 2", obs_sdrop);
        end
`endif
        for (int i = 0; i < 40; i++) tick(0, 32'h0, 1, 0);
        n_vec++;
        if (got_q.size() != 9) begin
            n_err++;
            $display("FAIL full_drain_count: got %0d words required 9", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 9; i++) begin
            n_vec++;
            if (got_q[i] !== 32'(i + 1)) begin
                n_err++;
                $display("FAIL full_drain_order[%0d]: got %h required %h", i, got_q[i], 32'(i + 1));
            end
        end
    endtask

    task automatic test_toggle_ready();
        int sent = 0;
        bit pv = 0, pr = 0;
        logic [31:0] pd = 32'h0;
        drain();
        got_q.delete();
        for (int c = 0; c < 200 && got_q.size() < 20; c++) begin
            bit w;
            w = (sent < 20) && (fq.size() < 7);
            tick(w, 32'h100 + sent, c[0], 0);
            if (w) sent++;
            if (pv && !pr) begin
                n_vec++;
                if (obs_valid !== 1'b1 || obs_data !== pd) begin
                    n_err++;
                    $display("FAIL toggle_stall_stable: valid=%b data=%h required valid=1 data=%h", obs_valid, obs_data, pd);
                end
            end
            pv = obs_valid; pd = obs_data; pr = c[0];
        end
        n_vec++;
        if (got_q.size() != 20) begin
            n_err++;
            $display("FAIL toggle_count: got %0d words required 20", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== 32'h100 + i) begin
                n_err++;
                $display("FAIL toggle_order[%0d]: got %h required %h", i, got_q[i], 32'h100 + i);
            end
        end
    endtask

    task automatic test_flush();
        int dones = 0;
        int bad_valid = 0;
        drain();
        rd_cnt = 0;
        for (int i = 0; i < 5; i++) tick(1, 32'h10 + i, 0, 0);
        tick(0, 32'h0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            tick(0, 32'h0, 0, (i == 1));
            if (obs_done === 1'b1) dones++;
            if (obs_valid !== 1'b0) bad_valid++;
        end
        n_vec++;
        if (dones != 1 || rd_cnt != 5 || bad_valid != 0 || obs_empty !== 1'b1) begin
            n_err++;
            $display("FAIL flush: done_pulses=%0d reads=%0d valid_cycles=%0d empty=%b required 1/5/0/1",
                     dones, rd_cnt, bad_valid, obs_empty);
        end
`ifdef FIFO_READ_CTRL_STATS_EN
        n_vec++;
        if (obs_sdel !== 16'h0 || obs_sdrop !== 8'h0) begin
            n_err++;
            $display("FAIL flush_stats_clear: delivered=%0d dropped=%0d required 0/0", obs_sdel, obs_sdrop);
        end
`endif
        got_q.delete();
        tick(1, 32'h55, 1, 0);
        for (int k = 0; k < 10 && got_q.size() == 0; k++) tick(0, 32'h0, 1, 0);
        n_vec++;
        if (got_q.size() != 1 || got_q[0] !== 32'h55) begin
            n_err++;
            $display("FAIL flush_then_write: got %0d words first=%h required 1 word 00000055",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bit w, r, f;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 60);
            f = ($urandom_range(0, 99) < 3);
            tick(w, $urandom, r, f);
            n_vec++;
            if ({obs_rd, obs_valid, obs_full, obs_empty, obs_done} !== {exp_rd, exp_valid, exp_full, exp_empty, exp_done}
                || (exp_valid && obs_data !== exp_data)) begin
                n_err++;
                $display("FAIL random_cycle%0d: rd/valid/full/empty/done=%b%b%b%b%b data=%h required %b%b%b%b%b data=%h",
                         c, obs_rd, obs_valid, obs_full, obs_empty, obs_done, obs_data,
                         exp_rd, exp_valid, exp_full, exp_empty, exp_done, exp_data);
            end
`ifdef FIFO_READ_CTRL_STATS_EN
            n_vec++;
            if (obs_sdel !== 16'(m_del) && !(exp_done) || obs_sdrop !== 8'(m_drop) && !(exp_done)) begin
                n_err++;
                $display("FAIL random_stats%0d: delivered=%0d dropped=%0d required %0d/%0d",
                         c, obs_sdel, obs_sdrop, m_del, m_drop);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b0; wr = 1'b0; rdy = 1'b0; fl = 1'b0; wdata = 32'h0; pend_d = 32'h0;
        rd_cnt = 0;
        reset_model();
        repeat (2) @(negedge clk);
        test_reset();
        test_latency();
        test_empty_write();
        test_full_backpressure();
        test_toggle_ready();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
